// File: rtl/id_decode_stage_if.sv
// Handshake bundle around the decode stage: fetch-side input and decoded output.
// No logic here; the stage uses the master view, the surrounding pipeline the slave view.
// Both sides use valid/ready; ready on the fetch side is driven from a register.
interface id_decode_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc_in;
  // decoded side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_out;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [2:0]      itype;
  logic [XLEN-1:0] imm;
  logic            illegal;

  // view taken by the decode stage itself
  modport master (
    input  in_valid, instruction, pc_in, out_ready,
    output in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
           funct3, funct7, itype, imm, illegal
  );

  // view taken by the fetch/execute environment around the stage
  modport slave (
    output in_valid, instruction, pc_in, out_ready,
    input  in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
           funct3, funct7, itype, imm, illegal
  );
endinterface

// File: rtl/id_decode_stage.sv
// Instruction decode stage: field split, format class, sign-extended immediate, illegal flag.
// Latency 1 cycle from accept to out_valid.
// 2-entry skid buffer; in_ready is registered (low only while the skid entry is full).
module id_decode_stage #(
  parameter int XLEN  = 32,
  parameter bit FP_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  id_decode_stage_if.master  bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      itype;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [2:0] T_R    = 3'b000;
  localparam logic [2:0] T_I    = 3'b001;
  localparam logic [2:0] T_U    = 3'b010;
  localparam logic [2:0] T_B    = 3'b011;
  localparam logic [2:0] T_S    = 3'b100;
  localparam logic [2:0] T_J    = 3'b101;
  localparam logic [2:0] T_IALU = 3'b110;
  localparam logic [2:0] T_BAD  = 3'b111;

  state_t             state;
  logic               out_valid_q;
  logic               in_ready_q;
  entry_t             out_q;
  entry_t             skid_q;

  logic [31:0]        inst;
  logic [2:0]         dec_type;
  logic signed [31:0] imm32;
  entry_t             dec;
  logic               accept;
  logic               xfer;

  assign inst   = bus.instruction;
  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = out_valid_q & bus.out_ready;

  // Format class from the opcode; anything unlisted (including inst[1:0] != 11) is illegal.
  always_comb begin
    dec_type = T_BAD;
    case (inst[6:0])
      7'b0110011: dec_type = T_R;
      7'b0010011: dec_type = T_IALU;
      7'b0000011,
      7'b1100111: dec_type = T_I;
      7'b0110111,
      7'b0010111: dec_type = T_U;
      7'b1100011: dec_type = T_B;
      7'b0100011: dec_type = T_S;
      7'b1101111: dec_type = T_J;
      7'b0000111: dec_type = FP_EN ? T_I : T_BAD;
      7'b0100111: dec_type = FP_EN ? T_S : T_BAD;
      default:    dec_type = T_BAD;
    endcase
  end

  // Immediate assembly: pack the field at the top of a word, then arithmetic-shift into place.
  always_comb begin
    imm32 = '0;
    case (dec_type)
      T_I, T_IALU: imm32 = $signed(inst) >>> 20;
      T_S:         imm32 = $signed({inst[31:25], inst[11:7], 20'b0}) >>> 20;
      T_B:         imm32 = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0, 19'b0}) >>> 19;
      T_U:         imm32 = $signed({inst[31:12], 12'b0});
      T_J:         imm32 = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0, 11'b0}) >>> 11;
      default:     imm32 = '0;
    endcase
  end

  // Decoded entry as it would be captured this cycle.
  always_comb begin
    dec         = '0;
    dec.pc      = bus.pc_in;
    dec.opcode  = inst[6:0];
    dec.rd      = inst[11:7];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.funct3  = inst[14:12];
    dec.funct7  = inst[31:25];
    dec.itype   = dec_type;
    dec.imm     = XLEN'(imm32);
    dec.illegal = (dec_type == T_BAD);
  end

  // Buffer control: output register plus skid entry, FIFO order, flush empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      out_q        <= '0;
      out_q.itype  <= T_BAD;
      skid_q       <= '0;
    end else if (flush) begin
      state        <= EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            out_q <= dec;
          end else if (accept) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (xfer) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pc_out    = out_q.pc;
  assign bus.opcode    = out_q.opcode;
  assign bus.rd        = out_q.rd;
  assign bus.rs1       = out_q.rs1;
  assign bus.rs2       = out_q.rs2;
  assign bus.funct3    = out_q.funct3;
  assign bus.funct7    = out_q.funct7;
  assign bus.itype     = out_q.itype;
  assign bus.imm       = out_q.imm;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed steps with a scoreboard of expected decoded entries.
// Entries are pushed on accept and popped on each output transfer.
// A second instance with FP_EN=0 checks that flw is flagged illegal there.
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  ty;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;

  id_decode_stage_if #(.XLEN(32)) bus_fp ();
  id_decode_stage_if #(.XLEN(32)) bus_nofp ();

  id_decode_stage #(.XLEN(32), .FP_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_fp)
  );

  id_decode_stage #(.XLEN(32), .FP_EN(1'b0)) dut_nofp (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_nofp)
  );

  int   total = 0;
  int   bad   = 0;
  int   xfers = 0;
  bit   last_acc;
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decoder written from the encoding tables with explicit bit assembly.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input bit fp);
    exp_t m;
    m.pc = pc;
    m.opcode = i[6:0];
    m.rd = i[11:7];
    m.rs1 = i[19:15];
    m.rs2 = i[24:20];
    m.f3 = i[14:12];
    m.f7 = i[31:25];
    case (i[6:0])
      7'b0110011: m.ty = 3'b000;
      7'b0010011: m.ty = 3'b110;
      7'b0000011: m.ty = 3'b001;
      7'b1100111: m.ty = 3'b001;
      7'b0110111: m.ty = 3'b010;
      7'b0010111: m.ty = 3'b010;
      7'b1100011: m.ty = 3'b011;
      7'b0100011: m.ty = 3'b100;
      7'b1101111: m.ty = 3'b101;
      7'b0000111: m.ty = fp ? 3'b001 : 3'b111;
      7'b0100111: m.ty = fp ? 3'b100 : 3'b111;
      default:    m.ty = 3'b111;
    endcase
    case (m.ty)
      3'b001, 3'b110: m.imm = {{20{i[31]}}, i[31:20]};
      3'b100:         m.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      3'b011:         m.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b010:         m.imm = {i[31:12], 12'h000};
      3'b101:         m.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:        m.imm = 32'h0;
    endcase
    m.ill = (m.ty == 3'b111);
    return m;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.pc = bus_fp.pc_out;
    o.opcode = bus_fp.opcode;
    o.rd = bus_fp.rd;
    o.rs1 = bus_fp.rs1;
    o.rs2 = bus_fp.rs2;
    o.f3 = bus_fp.funct3;
    o.f7 = bus_fp.funct7;
    o.ty = bus_fp.itype;
    o.imm = bus_fp.imm;
    o.ill = bus_fp.illegal;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: at the falling edge score any transfer, then record any accept.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_acc = bus_fp.in_valid && bus_fp.in_ready && !flush;
    if (bus_fp.out_valid && bus_fp.out_ready) begin
      xfers++;
      chk("sb_has_entry", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_entry", 128'(observe()), 128'(e));
      end
    end
    if (flush) sb.delete();
    else if (last_acc) sb.push_back(model(bus_fp.instruction, bus_fp.pc_in, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic send_imm(input logic [31:0] i, input logic [31:0] pc,
                          input logic [2:0] ety, input logic [31:0] eimm, input string tag);
    bus_fp.in_valid = 1'b1;
    bus_fp.instruction = i;
    bus_fp.pc_in = pc;
    bus_fp.out_ready = 1'b1;
    tick();
    bus_fp.in_valid = 1'b0;
    chk({tag, "_type"}, 128'(bus_fp.itype), 128'(ety));
    chk({tag, "_imm"}, 128'(bus_fp.imm), 128'(eimm));
    tick();
  endtask

  initial begin
    int x0;
    int n;
    logic [31:0] stream [4];
    stream[0] = 32'h00A00093;
    stream[1] = 32'h002081B3;
    stream[2] = 32'h0000A103;
    stream[3] = 32'hFE20AE23;

    rst_n = 1'b0;
    flush = 1'b0;
    bus_fp.in_valid = 1'b0;
    bus_fp.instruction = 32'h0;
    bus_fp.pc_in = 32'h0;
    bus_fp.out_ready = 1'b0;
    bus_nofp.in_valid = 1'b0;
    bus_nofp.instruction = 32'h0;
    bus_nofp.pc_in = 32'h0;
    bus_nofp.out_ready = 1'b1;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus_fp.out_valid), 128'd0);
    chk("rst_in_ready", 128'(bus_fp.in_ready), 128'd1);
    chk("rst_type", 128'(bus_fp.itype), 128'd7);
    chk("rst_illegal", 128'(bus_fp.illegal), 128'd0);
    chk("rst_imm", 128'(bus_fp.imm), 128'd0);
    chk("rst_pc_rd", 128'({bus_fp.pc_out, bus_fp.rd}), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single addi x1,x0,10
    bus_fp.in_valid = 1'b1;
    bus_fp.instruction = 32'h00A00093;
    bus_fp.pc_in = 32'h100;
    bus_fp.out_ready = 1'b1;
    tick();
    bus_fp.in_valid = 1'b0;
    chk("addi_valid", 128'(bus_fp.out_valid), 128'd1);
    chk("addi_type", 128'(bus_fp.itype), 128'd6);
    chk("addi_rd_rs1", 128'({bus_fp.rd, bus_fp.rs1}), 128'({5'd1, 5'd0}));
    chk("addi_imm", 128'(bus_fp.imm), 128'd10);
    chk("addi_illegal", 128'(bus_fp.illegal), 128'd0);
    chk("addi_pc", 128'(bus_fp.pc_out), 128'h100);
    tick();

    // streaming: four back-to-back, one transfer per cycle after the first
    x0 = xfers;
    for (int k = 0; k < 4; k++) begin
      bus_fp.in_valid = 1'b1;
      bus_fp.instruction = stream[k];
      bus_fp.pc_in = 32'h200 + 32'(4 * k);
      chk("stream_in_ready", 128'(bus_fp.in_ready), 128'd1);
      tick();
    end
    bus_fp.in_valid = 1'b0;
    tick();
    chk("stream_xfers", 128'(xfers - x0), 128'd4);
    chk("stream_drained", 128'(sb.size()), 128'd0);

    // backpressure: two accepted, third waits, then drain in order
    x0 = xfers;
    bus_fp.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_fp.in_valid = 1'b1;
      bus_fp.instruction = stream[k + 1];
      bus_fp.pc_in = 32'h300 + 32'(4 * k);
      tick();
    end
    chk("bp_in_ready_low", 128'(bus_fp.in_ready), 128'd0);
    bus_fp.instruction = 32'h12345037;
    bus_fp.pc_in = 32'h308;
    tick();
    tick();
    chk("bp_held", 128'({bus_fp.out_valid, bus_fp.in_ready, bus_fp.pc_out}), 128'({1'b1, 1'b0, 32'h300}));
    bus_fp.out_ready = 1'b1;
    n = 0;
    while ((bus_fp.in_valid || sb.size() != 0 || bus_fp.out_valid) && n < 12) begin
      tick();
      if (last_acc) bus_fp.in_valid = 1'b0;
      n++;
    end
    chk("bp_drain_in_time", 128'(n < 12), 128'd1);
    chk("bp_xfers", 128'(xfers - x0), 128'd3);

    // immediates
    send_imm(32'hFE20AE23, 32'h400, 3'b100, 32'hFFFFFFFC, "sw");
    send_imm(32'hFE000CE3, 32'h404, 3'b011, 32'hFFFFFFF8, "beq");
    send_imm(32'h001000EF, 32'h408, 3'b101, 32'h00000800, "jal");
    send_imm(32'h12345037, 32'h40C, 3'b010, 32'h12345000, "lui");

    // flw on both variants
    bus_nofp.in_valid = 1'b1;
    bus_nofp.instruction = 32'h0000A007;
    bus_fp.in_valid = 1'b1;
    bus_fp.instruction = 32'h0000A007;
    bus_fp.pc_in = 32'h500;
    tick();
    bus_fp.in_valid = 1'b0;
    bus_nofp.in_valid = 1'b0;
    chk("flw_fp_type", 128'(bus_fp.itype), 128'd1);
    chk("flw_nofp_type", 128'(bus_nofp.itype), 128'd7);
    chk("flw_nofp_illegal", 128'({bus_nofp.out_valid, bus_nofp.illegal}), 128'd3);
    tick();

    // flush while full, with an instruction offered at the same time
    x0 = xfers;
    bus_fp.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_fp.in_valid = 1'b1;
      bus_fp.instruction = stream[k];
      bus_fp.pc_in = 32'h600 + 32'(4 * k);
      tick();
    end
    chk("fl_two_in_ready", 128'(bus_fp.in_ready), 128'd0);
    bus_fp.instruction = stream[2];
    bus_fp.pc_in = 32'h608;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus_fp.in_valid = 1'b0;
    chk("fl_out_valid", 128'(bus_fp.out_valid), 128'd0);
    chk("fl_in_ready", 128'(bus_fp.in_ready), 128'd1);
    bus_fp.out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_nothing_out", 128'(xfers - x0), 128'd0);

    // flush with simultaneous accept and transfer: transfer counts, accept discarded
    x0 = xfers;
    bus_fp.out_ready = 1'b0;
    bus_fp.in_valid = 1'b1;
    bus_fp.instruction = stream[3];
    bus_fp.pc_in = 32'h700;
    tick();
    bus_fp.instruction = stream[1];
    bus_fp.pc_in = 32'h704;
    bus_fp.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus_fp.in_valid = 1'b0;
    chk("fl1_out_valid", 128'(bus_fp.out_valid), 128'd0);
    repeat (2) tick();
    chk("fl1_xfers", 128'(xfers - x0), 128'd1);

    // asynchronous reset mid-operation
    bus_fp.out_ready = 1'b0;
    bus_fp.in_valid = 1'b1;
    bus_fp.instruction = stream[0];
    bus_fp.pc_in = 32'h800;
    tick();
    bus_fp.in_valid = 1'b0;
    chk("ar_loaded", 128'(bus_fp.out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cleared", 128'({bus_fp.out_valid, bus_fp.in_ready, bus_fp.itype}), 128'({1'b0, 1'b1, 3'b111}));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // normal operation after reset
    x0 = xfers;
    bus_fp.out_ready = 1'b1;
    bus_fp.in_valid = 1'b1;
    bus_fp.instruction = stream[1];
    bus_fp.pc_in = 32'h900;
    tick();
    bus_fp.in_valid = 1'b0;
    repeat (2) tick();
    chk("post_xfers", 128'(xfers - x0), 128'd1);
    chk("post_drained", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
